// File: rtl/half_duplex_uart_phy_if.sv
// Bridge-side handshake bundle for the single-wire half-duplex UART PHY.
// The master is the passthrough bridge; the slave is the PHY.
interface half_duplex_uart_phy_if;
  logic       enable;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       busy;

  modport master (
    output enable, tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, busy
  );

  modport slave (
    input  enable, tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_frame_err, busy
  );
endinterface

// File: rtl/half_duplex_uart_phy.sv
// Single-wire half-duplex 8N1 UART PHY: serialises bridge bytes onto the pad,
// deserialises replies, owns the pad output-enable and the post-TX guard time.
module half_duplex_uart_phy #(
  parameter int unsigned CLK_FREQ_HZ = 72_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned GUARD_BITS  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  half_duplex_uart_phy_if.slave  bus,
  input  logic                   serial_i,
  output logic                   serial_o,
  output logic                   serial_oe
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       GUARD_LAST = 3'(GUARD_BITS - 1);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, TX_GUARD,
    RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_frame_err_q, rx_frame_err_d;
  logic             sync1_q, line_s_q, line_prev_q;
  logic             bit_end, fall, can_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      tx_byte_q      <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      sync1_q        <= 1'b1;
      line_s_q       <= 1'b1;
      line_prev_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      tx_byte_q      <= tx_byte_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      sync1_q        <= serial_i;
      line_s_q       <= sync1_q;
      line_prev_q    <= line_s_q;
    end
  end

  // One bit-time counter and one 3-bit index serve TX bits, guard bits and RX bits.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    tx_byte_d      = tx_byte_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    bit_end        = (cnt_q == BIT_LAST);
    cnt_next       = bit_end ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall) begin
          state_d = RX_START;
        end else if (bus.tx_valid && can_accept) begin
          tx_byte_d = bus.tx_data;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          state_d = TX_DATA;
          idx_d   = '0;
        end
      end
      TX_DATA: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          if (idx_q == 3'd7) state_d = TX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      TX_STOP: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          idx_d   = '0;
          state_d = (GUARD_BITS == 0) ? IDLE : TX_GUARD;
        end
      end
      TX_GUARD: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          if (idx_q == GUARD_LAST) state_d = IDLE;
          else                     idx_d   = idx_q + 3'd1;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = line_s_q ? IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          rx_shift_d = {line_s_q, rx_shift_q[7:1]};
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          if (line_s_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            state_d        = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        cnt_d = '0;
        if (line_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!bus.enable) begin
      state_d        = IDLE;
      cnt_d          = '0;
      idx_d          = '0;
      rx_valid_d     = 1'b0;
      rx_frame_err_d = 1'b0;
    end
  end

  always_comb begin
    fall       = line_prev_q & ~line_s_q;
    can_accept = bus.enable && (state_q == IDLE) && line_s_q && !fall;
    serial_oe  = 1'b0;
    serial_o   = 1'b1;
    unique case (state_q)
      TX_START: begin
        serial_oe = 1'b1;
        serial_o  = 1'b0;
      end
      TX_DATA: begin
        serial_oe = 1'b1;
        serial_o  = tx_byte_q[idx_q];
      end
      TX_STOP: serial_oe = 1'b1;
      default: ;
    endcase
    bus.tx_ready     = can_accept;
    bus.busy         = (state_q != IDLE);
    bus.rx_data      = rx_data_q;
    bus.rx_valid     = rx_valid_q;
    bus.rx_frame_err = rx_frame_err_q;
  end

endmodule

// File: tb/tb_half_duplex_uart_phy.sv
// Bench for half_duplex_uart_phy: frame-offset reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_half_duplex_uart_phy;

  localparam int CPB   = 20;
  localparam int HALF  = CPB / 2;
  localparam int GB    = 1;
  localparam int TXLEN = (10 + GB) * CPB;

  logic clk;
  logic rst_n;
  logic serial_o, serial_oe, pad_w;
  logic esc_en, esc_val;

  half_duplex_uart_phy_if bus_if ();

  half_duplex_uart_phy #(
    .CLK_FREQ_HZ(2_000_000),
    .BAUD_RATE  (100_000),
    .GUARD_BITS (GB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if),
    .serial_i (pad_w),
    .serial_o (serial_o),
    .serial_oe(serial_oe)
  );

  // Pad with weak pull-up; the PHY driver takes precedence over the far end.
  assign pad_w = serial_oe ? serial_o : (esc_en ? esc_val : 1'b1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int n_rxv = 0;
  int n_fe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the line/handshake must look like, tracked as the
  // current activity plus the number of cycles into it.
  typedef enum int {M_IDLE, M_TX, M_RX, M_RXW} mmode_e;
  mmode_e     mmode = M_IDLE;
  int         mr = 0;
  logic [7:0] mtx = '0, mbits = '0, mrx = '0;
  logic       mv = 1'b0, me = 1'b0;
  logic [3:0] h = 4'hF;

  always @(negedge clk) begin : model_check
    int k;
    logic [9:0] frame;
    logic e_oe, e_o, e_busy, e_rdy, pad, ls, lsp;
    if (!rst_n) begin
      chk("rst_oe", serial_oe, 0);
      chk("rst_so", serial_o, 1);
      chk("rst_busy", bus_if.busy, 0);
      chk("rst_rxv", bus_if.rx_valid, 0);
      chk("rst_fe", bus_if.rx_frame_err, 0);
      chk("rst_rxd", bus_if.rx_data, 0);
      chk("rst_rdy", bus_if.tx_ready, bus_if.enable);
      mmode = M_IDLE; mr = 0; mv = 1'b0; me = 1'b0; mrx = '0; h = 4'hF;
    end else begin
      e_oe = 1'b0;
      e_o  = 1'b1;
      if (mmode == M_TX && mr < 10 * CPB) begin
        frame = {1'b1, mtx, 1'b0};
        k     = mr / CPB;
        e_oe  = 1'b1;
        e_o   = frame[k];
      end
      e_busy = (mmode != M_IDLE);
      // line as seen through the 2-FF synchroniser: pad value two cycles back
      e_rdy  = bus_if.enable && (mmode == M_IDLE) && h[1];
      chk("oe", serial_oe, e_oe);
      chk("so", serial_o, e_o);
      chk("busy", bus_if.busy, e_busy);
      chk("tx_ready", bus_if.tx_ready, e_rdy);
      chk("rx_valid", bus_if.rx_valid, mv);
      chk("rx_frame_err", bus_if.rx_frame_err, me);
      chk("rx_data", bus_if.rx_data, mrx);
      n_rxv += int'(bus_if.rx_valid);
      n_fe  += int'(bus_if.rx_frame_err);

      pad = e_oe ? e_o : (esc_en ? esc_val : 1'b1);
      ls  = h[1];
      lsp = h[2];
      h   = {h[2:0], pad};
      mv  = 1'b0;
      me  = 1'b0;
      if (!bus_if.enable) begin
        mmode = M_IDLE;
      end else begin
        case (mmode)
          M_IDLE: begin
            if (lsp && !ls) begin
              mmode = M_RX; mr = 0;
            end else if (bus_if.tx_valid && ls) begin
              mmode = M_TX; mr = 0; mtx = bus_if.tx_data; accepts++;
            end
          end
          M_TX: begin
            mr++;
            if (mr == TXLEN) mmode = M_IDLE;
          end
          M_RX: begin
            if (mr >= HALF - 1 && (mr - (HALF - 1)) % CPB == 0) begin
              k = (mr - (HALF - 1)) / CPB;
              if (k == 0) begin
                if (ls) mmode = M_IDLE;
              end else if (k <= 8) begin
                mbits[k-1] = ls;
              end else if (ls) begin
                mv = 1'b1; mrx = mbits; mmode = M_IDLE;
              end else begin
                me = 1'b1; mmode = M_RXW;
              end
            end
            mr++;
          end
          M_RXW: if (ls) mmode = M_IDLE;
          default: mmode = M_IDLE;
        endcase
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_tx(input logic [7:0] b);
    int start, n;
    start = accepts;
    bus_if.tx_data  = b;
    bus_if.tx_valid = 1'b1;
    n = 0;
    while (accepts == start && n < 40 * CPB) begin
      cyc(1);
      n++;
    end
    bus_if.tx_valid = 1'b0;
    chk("tx_accept", accepts != start, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_v, input int stop_bits);
    esc_en  = 1'b1;
    esc_val = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      esc_val = b[i];
      cyc(CPB);
    end
    esc_val = stop_v;
    cyc(stop_bits * CPB);
    esc_val = 1'b1;
    esc_en  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (mmode != M_IDLE && n < 30 * CPB) begin
      cyc(1);
      n++;
    end
    chk("idle_wait", mmode == M_IDLE, 1);
    cyc(2);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] exp41;
    int rv0, fe0;
    rst_n = 1'b0;
    bus_if.enable   = 1'b0;
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = '0;
    esc_en  = 1'b0;
    esc_val = 1'b1;
    cyc(3);
    chk("lit_rst_oe", serial_oe, 0);
    chk("lit_rst_so", serial_o, 1);
    chk("lit_rst_busy", bus_if.busy, 0);
    chk("lit_rst_rxd", bus_if.rx_data, 8'h00);
    rst_n = 1'b1;
    bus_if.enable = 1'b1;
    cyc(5);

    // 0x41: line must read start, data LSB first, stop at each bit centre
    exp41 = 10'b1010000010;
    send_tx(8'h41);
    cyc(HALF);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) cyc(CPB);
      chk("lit_tx41_bit", serial_o, exp41[k]);
      chk("lit_tx41_oe", serial_oe, 1);
    end
    cyc(CPB - HALF - 1);
    chk("lit_tx41_oe_last", serial_oe, 1);
    cyc(1);
    chk("lit_tx41_oe_off", serial_oe, 0);
    cyc(CPB - 1);
    chk("lit_guard_rdy", bus_if.tx_ready, 0);
    cyc(1);
    chk("lit_after_guard_rdy", bus_if.tx_ready, 1);
    wait_idle();

    // 0xF4 reply
    rv0 = n_rxv; fe0 = n_fe;
    send_rx(8'hF4, 1'b1, 1);
    wait_idle();
    chk("lit_f4_count", n_rxv - rv0, 1);
    chk("lit_f4_fe", n_fe - fe0, 0);
    chk("lit_f4_data", bus_if.rx_data, 8'hF4);

    // short low glitch
    rv0 = n_rxv; fe0 = n_fe;
    esc_en = 1'b1; esc_val = 1'b0;
    cyc(6);
    esc_en = 1'b0; esc_val = 1'b1;
    cyc(HALF - 2);
    chk("lit_glitch_busy", bus_if.busy, 0);
    cyc(4);
    chk("lit_glitch_pulses", (n_rxv - rv0) + (n_fe - fe0), 0);

    // 0x00 with a stop bit held low for 5 bit times
    rv0 = n_rxv; fe0 = n_fe;
    send_rx(8'h00, 1'b0, 5);
    chk("lit_break_busy", bus_if.busy, 1);
    cyc(5);
    chk("lit_break_idle", bus_if.busy, 0);
    chk("lit_break_fe", n_fe - fe0, 1);
    chk("lit_break_rxv", n_rxv - rv0, 0);
    chk("lit_break_rxd", bus_if.rx_data, 8'hF4);
    wait_idle();

    // 0x99 aborted by enable during data bit 3
    send_tx(8'h99);
    cyc(4 * CPB + HALF);
    bus_if.enable = 1'b0;
    cyc(1);
    chk("lit_abort_oe", serial_oe, 0);
    chk("lit_abort_busy", bus_if.busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("lit_abort_rdy", bus_if.tx_ready, 0);
      cyc(1);
    end
    bus_if.enable = 1'b1;
    #1;
    chk("lit_reenable_rdy", bus_if.tx_ready, 1);
    cyc(2);

    // tx_valid raised in the cycle the synchronised falling edge appears
    rv0 = n_rxv;
    fork
      send_rx(8'h42, 1'b1, 1);
      begin
        cyc(2);
        chk("lit_collide_rdy", bus_if.tx_ready, 0);
        send_tx(8'h30);
        chk("lit_collide_rx_first", n_rxv - rv0, 1);
      end
    join
    wait_idle();
    chk("lit_42_data", bus_if.rx_data, 8'h42);

    // asynchronous reset mid-frame releases the line at once
    send_tx(8'hA5);
    cyc(3 * CPB);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_mid_oe", serial_oe, 0);
    chk("lit_rst_mid_busy", bus_if.busy, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);

    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          send_tx(8'($urandom));
          wait_idle();
        end
        1: begin
          send_rx(8'($urandom), 1'b1, 1);
          wait_idle();
        end
        2: begin
          send_rx(8'($urandom), 1'b0, int'($urandom_range(1, 3)));
          wait_idle();
        end
        3: begin
          esc_en = 1'b1; esc_val = 1'b0;
          cyc(int'($urandom_range(1, CPB)));
          esc_en = 1'b0; esc_val = 1'b1;
          wait_idle();
        end
        default: begin
          send_tx(8'($urandom));
          cyc(int'($urandom_range(1, 10 * CPB)));
          bus_if.enable = 1'b0;
          cyc(int'($urandom_range(1, 3)));
          bus_if.enable = 1'b1;
          wait_idle();
        end
      endcase
      cyc(int'($urandom_range(0, 2 * CPB)));
    end

    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
